// File: rtl/uart_echo_tx.sv
// UART echo transmitter: captures received bytes into a FIFO and re-sends them as 8N1 frames.
// Optional macro UART_ECHO_CRLF_EN appends 0x0A after every captured 0x0D.
module uart_echo_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  numRx,
  input  logic                        rxDataRdy,
  output logic                        RsTx,
  output logic                        txBusy,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
  output logic                        overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int TW  = $clog2(DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic          w_edge;
  logic          w_push;
  logic [7:0]    w_din;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_en;
  logic          w_pop;
  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic          w_tick;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= rxDataRdy;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_prev;

`ifdef UART_ECHO_CRLF_EN
  // A captured CR schedules an LF push on the following cycle.
  logic r_lf_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lf_pend <= 1'b0;
    else        r_lf_pend <= w_edge && (numRx == 8'h0D);
  end

  assign w_push = w_edge | r_lf_pend;
  assign w_din  = r_lf_pend ? 8'h0A : numRx;
`else
  assign w_push = w_edge;
  assign w_din  = numRx;
`endif

  assign w_count   = r_wr - r_rd;
  assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_wr == r_rd);
  assign w_wr_en   = w_push & ~w_full;
  assign fifoCount = w_count;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= w_din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr     <= '0;
      r_rd     <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_wr_en)         r_wr     <= r_wr + 1'b1;
      if (w_pop)           r_rd     <= r_rd + 1'b1;
      if (w_push & w_full) overflow <= 1'b1;
    end
  end

  assign w_tick = (r_timer == TW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE || w_tick) r_timer <= '0;
      else                             r_timer <= r_timer + 1'b1;
      if (w_pop) begin
        r_shift <= r_mem[r_rd[AW-1:0]];
        r_bit   <= '0;
      end else if (r_state == S_DATA && w_tick) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_START;
      S_START: if (w_tick) w_next = S_DATA;
      S_DATA:  if (w_tick && r_bit == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_tick) w_next = w_empty ? S_IDLE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  // Stop-bit end pops directly so consecutive frames have no idle gap.
  always_comb begin
    RsTx   = 1'b1;
    txBusy = 1'b0;
    w_pop  = 1'b0;
    unique case (r_state)
      S_IDLE: w_pop = ~w_empty;
      S_START: begin
        RsTx   = 1'b0;
        txBusy = 1'b1;
      end
      S_DATA: begin
        RsTx   = r_shift[0];
        txBusy = 1'b1;
      end
      S_STOP: begin
        txBusy = 1'b1;
        w_pop  = w_tick & ~w_empty;
      end
      default: RsTx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_echo_tx.sv
// Testbench for uart_echo_tx: frame decoder on RsTx plus directed and random byte streams.
// DIV = 10 clocks per bit, FIFO depth 8.
module tb_uart_echo_tx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxDataRdy = 1'b0;
  logic [7:0] numRx = 8'h00;
  logic       RsTx;
  logic       txBusy;
  logic       overflow;
  logic [3:0] fifoCount;

  uart_echo_tx #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .numRx    (numRx),
    .rxDataRdy(rxDataRdy),
    .RsTx     (RsTx),
    .txBusy   (txBusy),
    .fifoCount(fifoCount),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int peak = 0;
  int busy = 0;
  int rd = 0;
  logic [7:0] exp_q[$];

  logic [7:0] mon_q[$];
  int         mon_t[$];
  int         mon_bad = 0;

  // Decodes frames: samples mid-bit, abandons a frame if reset hits.
  always begin : mon
    logic [7:0] b;
    logic       ok;
    int         st;
    bit         ab;
    @(negedge clk);
    if (reset === 1'b1 && RsTx === 1'b0) begin
      st = cyc;
      ok = 1'b1;
      ab = 1'b0;
      b  = 8'h00;
      for (int i = 0; i < 10; i++) begin
        repeat (i == 0 ? 5 : 10) @(negedge clk);
        if (reset !== 1'b1) begin
          ab = 1'b1;
          break;
        end
        if (i == 0 && RsTx !== 1'b0) ok = 1'b0;
        else if (i == 9 && RsTx !== 1'b1) ok = 1'b0;
        else if (i > 0 && i < 9) b[i-1] = RsTx;
      end
      if (!ab) begin
        mon_q.push_back(b);
        mon_t.push_back(st);
        if (!ok) mon_bad++;
        repeat (4) @(negedge clk);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (fifoCount > peak) peak = fifoCount;
      if (txBusy === 1'b1) busy++;
    end
  endtask

  task automatic strobe(input logic [7:0] b, input int hi, input int lo);
    numRx     = b;
    rxDataRdy = 1'b1;
    step(hi);
    rxDataRdy = 1'b0;
    step(lo);
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && mon_q.size() < n; i++) step(1);
    check("frame_timeout", 32'(mon_q.size() >= n), 1);
  endtask

  task automatic check_bytes(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, (rd < mon_q.size()) ? 32'(mon_q[rd]) : 32'hFFFF_FFFF,
            32'(exp_q[i]));
      rd++;
    end
    exp_q.delete();
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h0D) b = 8'h0C;
    return b;
  endfunction

  initial begin
    int c0;
    int base;
    int qn;
    logic [7:0] b;

    step(3);
    check("rst_rstx", RsTx, 1);
    check("rst_busy", txBusy, 0);
    check("rst_count", fifoCount, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b1;
    step(5);

    // single byte 0xA5
    busy = 0;
    c0 = cyc;
    numRx = 8'hA5;
    rxDataRdy = 1'b1;
    step(3);
    check("t1_push", fifoCount, 1);
    step(1);
    check("t1_start", RsTx, 0);
    check("t1_pop", fifoCount, 0);
    check("t1_busy_on", txBusy, 1);
    step(46);
    rxDataRdy = 1'b0;
    step(80);
    wait_frames(1, 50);
    check("t1_latency", mon_t[0] - c0, 4);
    check("t1_frames", mon_q.size(), 1);
    check("t1_busy_len", busy, 100);
    exp_q.push_back(8'hA5);
    check_bytes("t1_byte");

    // burst of five
    peak = 0;
    base = mon_q.size();
    for (int i = 1; i <= 5; i++) begin
      strobe(8'(i), 2, 18);
      exp_q.push_back(8'(i));
    end
    wait_frames(base + 5, 600);
    check("t2_peak", peak, 4);
    for (int i = 1; i < 5; i++)
      check("t2_gap", mon_t[base+i] - mon_t[base+i-1], 100);
    check_bytes("t2_byte");
    step(20);

    // overflow: ten strobes during the first frame
    check("t3_ovf_before", overflow, 0);
    base = mon_q.size();
    qn = 0;
    for (int i = 0; i < 10; i++) begin
      b = rnd_byte();
      strobe(b, 2, 3);
      if (i == 0) exp_q.push_back(b);
      else if (qn < DEPTH) begin
        exp_q.push_back(b);
        qn++;
      end
    end
    check("t3_ovf", overflow, 1);
    wait_frames(base + 9, 1200);
    step(150);
    check("t3_frames", mon_q.size(), base + 9);
    check_bytes("t3_byte");

    // reset in DATA bit 3
    base = mon_q.size();
    c0 = cyc;
    strobe(rnd_byte(), 2, 3);
    strobe(rnd_byte(), 2, 3);
    step(39);
    check("t4_queued", fifoCount, 1);
    check("t4_busy", txBusy, 1);
    reset = 1'b0;
    #1;
    check("t4_rstx", RsTx, 1);
    check("t4_count", fifoCount, 0);
    check("t4_busy_off", txBusy, 0);
    check("t4_ovf_clr", overflow, 0);
    step(20);
    reset = 1'b1;
    step(300);
    check("t4_noframe", mon_q.size(), base);
    check("t4_idle", RsTx, 1);
    rd = mon_q.size();

    // random bytes at random spacing
    base = mon_q.size();
    for (int i = 0; i < 6; i++) begin
      b = rnd_byte();
      exp_q.push_back(b);
      strobe(b, 2, $urandom_range(38, 10));
    end
    wait_frames(base + 6, 900);
    check_bytes("t5_byte");
    check("t5_ovf", overflow, 0);

    // carriage return
    step(20);
    base = mon_q.size();
    strobe(8'h0D, 2, 3);
    exp_q.push_back(8'h0D);
`ifdef UART_ECHO_CRLF_EN
    exp_q.push_back(8'h0A);
    wait_frames(base + 2, 400);
    check("t6_gap", mon_t[base+1] - mon_t[base], 100);
    step(150);
    check("t6_frames", mon_q.size(), base + 2);
`else
    wait_frames(base + 1, 300);
    step(150);
    check("t6_frames", mon_q.size(), base + 1);
`endif
    check_bytes("t6_byte");

    check("framing", mon_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
